math_trig_pipe: RTL and testbench
=================================

Name: math_trig_pipe

Overview:
- Pipelined, multi-function floating-point trig unit; successor to the single-function combinational cos/sin wrappers in the Math library.
- Computes cos, sin or tan of a WIDTH-bit float, selected per transaction, through LATENCY registered stages with full valid/ready backpressure and a passthrough tag.
- Sits in the dataflow PE function-unit slot; simulation-behavioural arithmetic (real/shortreal system functions), cycle-accurate handshake.

Parameters:
- WIDTH, 32, float width; 32 (f32) or 64 (f64) only, any other value triggers $fatal at elaboration.
- LATENCY, 3, number of pipeline stages, range 1..16; values outside this range trigger $fatal.
- TAG_WIDTH, 4, width of the opaque tag carried alongside each transaction, range 1..16.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- a_valid  in  1  input transaction valid
- a_ready  out  1  input transaction accepted when a_valid && a_ready
- a_data  in  WIDTH  operand bits, IEEE-754
- a_op  in  2  function select: 0=cos, 1=sin, 2=tan, 3=reserved
- a_tag  in  TAG_WIDTH  opaque tag, returned unchanged with the result
- result_valid  out  1  output valid
- result_ready  in  1  downstream accept
- result_data  out  WIDTH  result bits
- result_tag  out  TAG_WIDTH  tag of the current output

Behaviour:
- Reset (rst=1 at a clk edge):
  - all stage valid bits clear;
  - result_valid=0, result_data=0, result_tag=0;
  - a_ready=1 in the cycle after reset.
- Reset mid-operation: all in-flight transactions are discarded, with no output for them. a_ready is forced to 0 while rst=1.
- Arithmetic:
  - Evaluated at acceptance and stored in stage 0; the data travels with the transaction.
  - f32 path: operand converted to real, function applied, result rounded back to shortreal.
  - f64 path: evaluated directly in real.
  - op=3 returns canonical quiet NaN: 0x7FC00000 (f32) or 0x7FF8000000000000 (f64).
  - NaN or infinite operands propagate whatever the system function yields.
- Pipeline:
  - LATENCY stages S0..S(L-1), each holding valid, data and tag.
  - Stage i loads from stage i-1 (S0 loads from the input) when stage i is empty or is advancing.
  - The last stage advances when result_ready=1.
  - Pipeline is bubble-collapsing: empty stages are filled even while the output is stalled.
- Handshake:
  - a_ready = !S0.valid || S0 advancing. This is combinational from result_ready through the advance chain; no registered skid.
  - result_valid = S(L-1).valid. result_data and result_tag are driven directly from S(L-1) and are held stable while result_valid && !result_ready.
  - Once asserted, result_valid stays high until the handshake completes.
- Latency and throughput:
  - Accepted in cycle t with no stall: result_valid=1 in cycle t+LATENCY.
  - Sustained throughput is 1 transaction/cycle with result_ready tied high.
  - Capacity is LATENCY transactions. When all stages are full and result_ready=0, a_ready=0.
- Simultaneous events:
  - With a full pipe and result_ready=1, a new input is accepted in the same cycle as the output handshake.
  - No transaction is lost or duplicated.
- Ordering: results leave in acceptance order; no reordering.

Optional Feature:
- Macro: MATH_TRIG_PIPE_EXC_FLAG_EN.
- When defined:
  - Extra output result_exc (out, 1).
  - result_exc=1 when the operand was NaN or ±inf, or op=3. The flag is computed at acceptance and carried through the pipeline with the transaction.
  - Reset value is 0.
- When undefined: the port is absent and no flag logic is generated. Datapath and timing are identical in both builds.

Test Plan:
- WIDTH=32, LATENCY=3, result_ready=1; accept cos, a_data=0x00000000, tag=5 at cycle t -> result_valid at t+3, result_data=0x3F800000, result_tag=5.
- Back-to-back sin(0), cos(0), op=3 with tags 1, 2, 3 -> outputs on three consecutive cycles:
  - 0x00000000 tag 1;
  - 0x3F800000 tag 2;
  - 0x7FC00000 tag 3.
- Hold result_ready=0 and stream inputs -> exactly 3 accepted, then a_ready=0. First result held stable. Release result_ready -> 3 results in order, then a_ready returns to 1.
- Full pipe with result_ready=1 and a_valid=1 on the same cycle -> one output and one input handshake in that cycle, and occupancy stays 3.
- Assert rst for 1 cycle with 2 transactions in flight -> no result_valid ever appears for them; result_valid=0 and result_data=0 after reset; new transaction latency is exactly LATENCY.
- WIDTH=64, LATENCY=1: cos(0) -> 0x3FF0000000000000 next cycle.
- With MATH_TRIG_PIPE_EXC_FLAG_EN: sin(0x7F800000) -> result_exc=1.

Source files
------------

// File: rtl/math_trig_pipe.sv
// Pipelined cos/sin/tan unit with valid/ready backpressure and a passthrough tag.
// Optional result_exc output enabled by defining MATH_TRIG_PIPE_EXC_FLAG_EN.
module math_trig_pipe #(
   parameter int WIDTH     = 32,
   parameter int LATENCY   = 3,
   parameter int TAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [WIDTH-1:0]     a_data,
   input  logic [1:0]           a_op,
   input  logic [TAG_WIDTH-1:0] a_tag,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic [WIDTH-1:0]     result_data,
   output logic [TAG_WIDTH-1:0] result_tag
`ifdef MATH_TRIG_PIPE_EXC_FLAG_EN
   ,
   output logic                 result_exc
`endif
);

   localparam int EXP_W = (WIDTH == 64) ? 11 : 8;

   generate
      if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
         $fatal(1, "math_trig_pipe: WIDTH must be 32 or 64");
      end
      if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
         $fatal(1, "math_trig_pipe: LATENCY must be in 1..16");
      end
   endgenerate

   // f32 -> f64 widening, including normalisation of subnormals.
   function automatic logic [63:0] f32_to_f64(input logic [31:0] f);
      logic [7:0]  e;
      logic [22:0] m;
      logic [63:0] t;
      logic [10:0] e64;
      logic [51:0] m64;
      int          p;
      e   = f[30:23];
      m   = f[22:0];
      p   = 0;
      t   = '0;
      e64 = '0;
      m64 = '0;
      if (e == 8'hFF) begin
         e64 = 11'h7FF;
         m64 = {m, 29'b0};
      end else if (e == 8'h00 && m != 23'h0) begin
         for (int k = 0; k < 23; k++)
            if (m[k]) p = k;
         t   = {41'b0, m} << (52 - p);
         e64 = 11'(p + 874);
         m64 = t[51:0];
      end else if (e != 8'h00) begin
         e64 = 11'(int'(e) + 896);
         m64 = {m, 29'b0};
      end
      return {f[31], e64, m64};
   endfunction

   // f64 -> f32 narrowing with round-to-nearest-even, subnormal and overflow handling.
   function automatic logic [31:0] f64_to_f32(input logic [63:0] d);
      logic [10:0] e;
      logic [51:0] m;
      logic [63:0] sig, kept, rem, half;
      logic [30:0] mag;
      logic        up;
      int          e32, sh;
      e    = d[62:52];
      m    = d[51:0];
      sig  = {11'b0, 1'b1, m};
      e32  = int'(e) - 896;
      mag  = '0;
      up   = 1'b0;
      kept = '0;
      rem  = '0;
      half = '0;
      sh   = 0;
      if (e == 11'h7FF) begin
         mag = (m == 52'h0) ? {8'hFF, 23'h0} : {8'hFF, 1'b1, m[50:29]};
      end else if (e == 11'h0) begin
         mag = '0;
      end else if (e32 >= 255) begin
         mag = {8'hFF, 23'h0};
      end else if (e32 >= 1) begin
         // a carry out of the mantissa bumps the exponent, up to infinity
         up  = m[28] && ((m[27:0] != 28'h0) || m[29]);
         mag = {e32[7:0], m[51:29]} + 31'(up);
      end else begin
         sh = 30 - e32;
         if (sh <= 54) begin
            kept = sig >> sh;
            rem  = sig & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            up   = (rem > half) || (rem == half && kept[0]);
            mag  = kept[30:0] + 31'(up);
         end
      end
      return {d[63], mag};
   endfunction

   function automatic logic [WIDTH-1:0] trig_eval(input logic [WIDTH-1:0] x,
                                                  input logic [1:0]       op);
      logic [63:0] xw, rw;
      real         r, y;
      xw = 64'(x);
      r  = (WIDTH == 32) ? $bitstoreal(f32_to_f64(xw[31:0])) : $bitstoreal(xw);
      case (op)
         2'd0:    y = $cos(r);
         2'd1:    y = $sin(r);
         2'd2:    y = $tan(r);
         default: y = 0.0;
      endcase
      rw = (WIDTH == 32) ? {32'h0, f64_to_f32($realtobits(y))} : $realtobits(y);
      if (op == 2'd3)
         rw = (WIDTH == 32) ? 64'h0000_0000_7FC0_0000 : 64'h7FF8_0000_0000_0000;
      return WIDTH'(rw);
   endfunction

   logic [LATENCY-1:0]                vld_pipe;
   logic [LATENCY-1:0][WIDTH-1:0]     data_pipe;
   logic [LATENCY-1:0][TAG_WIDTH-1:0] tag_pipe;
   logic [LATENCY-1:0]                in_vld;
   logic [LATENCY-1:0][WIDTH-1:0]     in_data;
   logic [LATENCY-1:0][TAG_WIDTH-1:0] in_tag;
   logic [LATENCY-1:0]                load;
   logic [LATENCY-1:0]                adv;
   logic [WIDTH-1:0]                  s0_data;

   assign s0_data    = trig_eval(a_data, a_op);
   assign in_vld[0]  = a_valid;
   assign in_data[0] = s0_data;
   assign in_tag[0]  = a_tag;

   genvar gi;
   generate
      for (gi = 1; gi < LATENCY; gi++) begin : g_link
         assign in_vld[gi]  = vld_pipe[gi-1];
         assign in_data[gi] = data_pipe[gi-1];
         assign in_tag[gi]  = tag_pipe[gi-1];
      end
   endgenerate

   // Advance chain walks back from the output so empty stages keep filling under stall.
   always_comb begin
      logic nxt;
      load = '0;
      adv  = '0;
      nxt  = result_ready;
      for (int i = LATENCY - 1; i >= 0; i--) begin
         adv[i]  = vld_pipe[i] && nxt;
         load[i] = !vld_pipe[i] || adv[i];
         nxt     = load[i];
      end
   end

   assign a_ready = !rst && load[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe  <= '0;
         data_pipe <= '0;
         tag_pipe  <= '0;
      end else begin
         for (int i = 0; i < LATENCY; i++) begin
            if (load[i]) begin
               vld_pipe[i]  <= in_vld[i];
               data_pipe[i] <= in_data[i];
               tag_pipe[i]  <= in_tag[i];
            end
         end
      end
   end

   assign result_valid = vld_pipe[LATENCY-1];
   assign result_data  = data_pipe[LATENCY-1];
   assign result_tag   = tag_pipe[LATENCY-1];

`ifdef MATH_TRIG_PIPE_EXC_FLAG_EN
   logic [LATENCY-1:0] exc_pipe;
   logic [LATENCY-1:0] in_exc;

   assign in_exc[0] = (a_data[WIDTH-2 -: EXP_W] == {EXP_W{1'b1}}) || (a_op == 2'd3);
   generate
      for (gi = 1; gi < LATENCY; gi++) begin : g_exc_link
         assign in_exc[gi] = exc_pipe[gi-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         exc_pipe <= '0;
      end else begin
         for (int i = 0; i < LATENCY; i++)
            if (load[i]) exc_pipe[i] <= in_exc[i];
      end
   end

   assign result_exc = exc_pipe[LATENCY-1];
`endif

endmodule

// File: tb/tb_math_trig_pipe.sv
// Bench for math_trig_pipe: f32/L=3 instance with table, directed and random traffic,
// plus an f64/L=1 instance; result_exc checked when MATH_TRIG_PIPE_EXC_FLAG_EN is defined.
module tb_math_trig_pipe;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, a_valid, a_ready, result_valid, result_ready;
   logic [31:0] a_data, result_data;
   logic [1:0]  a_op;
   logic [3:0]  a_tag, result_tag;

   logic        b_valid, b_ready, r64_valid, r64_ready;
   logic [63:0] b_data, r64_data;
   logic [1:0]  b_op;
   logic [3:0]  b_tag, r64_tag;
`ifdef MATH_TRIG_PIPE_EXC_FLAG_EN
   logic        result_exc, r64_exc;
`endif

   math_trig_pipe #(.WIDTH(32), .LATENCY(LAT), .TAG_WIDTH(4)) u_dut (
      .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
      .a_op(a_op), .a_tag(a_tag), .result_valid(result_valid), .result_ready(result_ready),
      .result_data(result_data), .result_tag(result_tag)
`ifdef MATH_TRIG_PIPE_EXC_FLAG_EN
      , .result_exc(result_exc)
`endif
   );

   math_trig_pipe #(.WIDTH(64), .LATENCY(1), .TAG_WIDTH(4)) u_dut64 (
      .clk(clk), .rst(rst), .a_valid(b_valid), .a_ready(b_ready), .a_data(b_data),
      .a_op(b_op), .a_tag(b_tag), .result_valid(r64_valid), .result_ready(r64_ready),
      .result_data(r64_data), .result_tag(r64_tag)
`ifdef MATH_TRIG_PIPE_EXC_FLAG_EN
      , .result_exc(r64_exc)
`endif
   );

   int n_tests = 0, n_fail = 0, cyc = 0, last_lat = 0;
   bit acc, ouths, hold_v;
   logic [35:0] hold_val;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  tag;
      bit          any_nan;
      bit          exc;
      bit          chk_lat;
      int          acc_cyc;
   } exp_t;
   exp_t expq[$];

   typedef struct {
      logic [31:0] data;
      logic [1:0]  op;
      logic [3:0]  tag;
      logic [31:0] res;
      bit          any_nan;
   } vec_t;

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // ---------------- reference model: plain real arithmetic ----------------
   function automatic real pow2(int k);
      real p = 1.0;
      if (k >= 0) repeat (k) p = p * 2.0;
      else        repeat (-k) p = p / 2.0;
      return p;
   endfunction

   function automatic real f32_val(logic [31:0] x);
      real v;
      int  e = int'(x[30:23]);
      if (e == 0) v = real'(x[22:0]) * pow2(-149);
      else        v = (1.0 + real'(x[22:0]) * pow2(-23)) * pow2(e - 127);
      return x[31] ? -v : v;
   endfunction

   function automatic longint round_even(real q);
      real fl = $floor(q);
      real d  = q - fl;
      if (d > 0.5 || (d == 0.5 && ($rtoi(fl) % 2) == 1)) fl = fl + 1.0;
      return longint'(fl);
   endfunction

   function automatic logic [31:0] to_f32(real r);
      logic [63:0] rb;
      logic        s;
      real         a, mag;
      int          e = 0;
      longint      m;
      rb  = $realtobits(r);
      s   = rb[63];
      mag = (r < 0.0) ? -r : r;
      a   = mag;
      if (a == 0.0) return {s, 31'h0};
      while (a >= 2.0 && e < 300) begin a = a / 2.0; e++; end
      while (a < 1.0) begin a = a * 2.0; e--; end
      if (e > 127) return {s, 8'hFF, 23'h0};
      if (e < -126) begin
         m = round_even(mag * pow2(149));
         return {s, m[30:0]};
      end
      m = round_even((a - 1.0) * pow2(23)) + (longint'(e + 127) << 23);
      return {s, m[30:0]};
   endfunction

   function automatic logic [31:0] model32(logic [31:0] x, logic [1:0] op);
      real r = f32_val(x);
      case (op)
         2'd0:    return to_f32($cos(r));
         2'd1:    return to_f32($sin(r));
         2'd2:    return to_f32($tan(r));
         default: return 32'h7FC00000;
      endcase
   endfunction

   function automatic logic [31:0] rand_f32();
      logic [31:0] r = $urandom;
      logic [7:0]  e;
      e = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(100, 140));
      return {r[31], e, r[22:0]};
   endfunction

   function automatic bit is_nan32(logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'h0);
   endfunction

   // One clock: drive at the falling edge, sample 1ns later, score handshakes.
   task automatic cycle(bit v, logic [31:0] d, logic [1:0] op, logic [3:0] tag, bit rr,
                        bit r, logic [31:0] ed, bit anynan, bit chklat);
      exp_t e;
      @(negedge clk);
      a_valid = v; a_data = d; a_op = op; a_tag = tag; result_ready = rr; rst = r;
      #1;
      if (hold_v && !r) begin
         check("stall_valid_held", 64'(result_valid), 64'd1);
         check("stall_output_held", 64'({result_tag, result_data}), 64'(hold_val));
      end
      acc   = !r && v && a_ready;
      ouths = !r && result_valid && rr;
      if (ouths) begin
         if (expq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL spurious_output: got data %h tag %h, expected no output", result_data, result_tag);
         end else begin
            e = expq.pop_front();
            last_lat = cyc - e.acc_cyc;
            if (e.any_nan) check("result_is_nan", 64'(is_nan32(result_data)), 64'd1);
            else           check("result_data", 64'(result_data), 64'(e.data));
            check("result_tag", 64'(result_tag), 64'(e.tag));
            if (e.chk_lat) check("latency", 64'(last_lat), 64'(LAT));
`ifdef MATH_TRIG_PIPE_EXC_FLAG_EN
            check("result_exc", 64'(result_exc), 64'(e.exc));
`endif
         end
      end
      if (acc) begin
         e.data = ed; e.tag = tag; e.any_nan = anynan; e.chk_lat = chklat; e.acc_cyc = cyc;
         e.exc = (d[30:23] == 8'hFF) || (op == 2'd3);
         expq.push_back(e);
      end
      if (r) expq.delete();
      hold_v   = !r && result_valid && !rr;
      hold_val = {result_tag, result_data};
      cyc++;
   endtask

   task automatic send(bit v, logic [31:0] d, logic [1:0] op, logic [3:0] tag, bit rr, bit chklat);
      cycle(v, d, op, tag, rr, 1'b0, model32(d, op), 1'b0, chklat);
   endtask

   task automatic idle(bit rr);
      cycle(1'b0, 32'h0, 2'd0, 4'h0, rr, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic drain(int budget);
      int n = 0;
      while (expq.size() != 0 && n < budget) begin idle(1'b1); n++; end
      n_tests++;
      if (expq.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d results outstanding, expected 0", expq.size());
      end
   endtask

   vec_t vecs[14];
   int   nacc;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{32'h00000000, 2'd1, 4'd1,  32'h00000000, 1'b0};
      vecs[1]  = '{32'h00000000, 2'd0, 4'd2,  32'h3F800000, 1'b0};
      vecs[2]  = '{32'h00000000, 2'd3, 4'd3,  32'h7FC00000, 1'b0};
      vecs[3]  = '{32'h00000000, 2'd2, 4'd4,  32'h00000000, 1'b0};
      vecs[4]  = '{32'h80000000, 2'd1, 4'd5,  32'h80000000, 1'b0};
      vecs[5]  = '{32'h80000000, 2'd2, 4'd6,  32'h80000000, 1'b0};
      vecs[6]  = '{32'h80000000, 2'd0, 4'd7,  32'h3F800000, 1'b0};
      vecs[7]  = '{32'h3FC90FDB, 2'd1, 4'd8,  32'h3F800000, 1'b0};
      vecs[8]  = '{32'h00000001, 2'd0, 4'd9,  32'h3F800000, 1'b0};
      vecs[9]  = '{32'h00000001, 2'd1, 4'd10, 32'h00000001, 1'b0};
      vecs[10] = '{32'h00800000, 2'd1, 4'd11, 32'h00800000, 1'b0};
      vecs[11] = '{32'h7F800000, 2'd3, 4'd12, 32'h7FC00000, 1'b0};
      vecs[12] = '{32'h7F800000, 2'd1, 4'd13, 32'h00000000, 1'b1};
      vecs[13] = '{32'h7FC00000, 2'd0, 4'd14, 32'h00000000, 1'b1};

      rst = 1'b1; a_valid = 1'b0; a_data = '0; a_op = '0; a_tag = '0; result_ready = 1'b1;
      b_valid = 1'b0; b_data = '0; b_op = '0; b_tag = '0; r64_ready = 1'b1;
      hold_v = 1'b0; hold_val = '0;
      cycle(1'b0, 32'h0, 2'd0, 4'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 2'd0, 4'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);

      // reset state
      idle(1'b1);
      check("reset_result_valid", 64'(result_valid), 64'd0);
      check("reset_result_data", 64'(result_data), 64'd0);
      check("reset_result_tag", 64'(result_tag), 64'd0);
      check("reset_a_ready", 64'(a_ready), 64'd1);

      // single cos(0), tag 5
      cycle(1'b1, 32'h0, 2'd0, 4'd5, 1'b1, 1'b0, 32'h3F800000, 1'b0, 1'b1);
      drain(10);

      // table, back to back
      foreach (vecs[i])
         cycle(1'b1, vecs[i].data, vecs[i].op, vecs[i].tag, 1'b1, 1'b0, vecs[i].res, vecs[i].any_nan, 1'b1);
      drain(10);

      // stalled output: fills to 3, then a_ready drops
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         send(1'b1, rand_f32(), 2'($urandom_range(0, 2)), 4'(i + 1), 1'b0, 1'b0);
         if (acc) nacc++;
      end
      check("stall_accept_count", 64'(nacc), 64'd3);
      check("stall_a_ready_low", 64'(a_ready), 64'd0);

      // full pipe: output and input handshake in the same cycle
      send(1'b1, rand_f32(), 2'd1, 4'd9, 1'b1, 1'b0);
      check("full_pipe_input_hs", 64'(acc), 64'd1);
      check("full_pipe_output_hs", 64'(ouths), 64'd1);
      send(1'b1, rand_f32(), 2'd0, 4'd10, 1'b0, 1'b0);
      check("occupancy_still_full", 64'(acc), 64'd0);
      drain(10);
      idle(1'b1);
      check("a_ready_after_drain", 64'(a_ready), 64'd1);

      // reset with two in flight
      send(1'b1, rand_f32(), 2'd0, 4'd1, 1'b1, 1'b0);
      send(1'b1, rand_f32(), 2'd1, 4'd2, 1'b1, 1'b0);
      cycle(1'b1, 32'h0, 2'd0, 4'h3, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      check("a_ready_in_reset", 64'(a_ready), 64'd0);
      idle(1'b1);
      check("post_reset_valid", 64'(result_valid), 64'd0);
      check("post_reset_data", 64'(result_data), 64'd0);
      repeat (5) idle(1'b1);
      send(1'b1, 32'h3F800000, 2'd1, 4'd7, 1'b1, 1'b1);
      drain(10);

      // random traffic against the model
      for (int i = 0; i < 400; i++)
         send(1'($urandom_range(0, 3) != 0), rand_f32(), 2'($urandom_range(0, 3)),
              4'($urandom), 1'($urandom_range(0, 4) != 0), 1'b0);
      drain(20);

      // f64, LATENCY=1
      begin
         logic [63:0] xd[9];
         logic [1:0]  xo[9];
         logic [63:0] xe[9];
         real         rv;
         xd[0] = 64'h0; xo[0] = 2'd0; xe[0] = 64'h3FF0000000000000;
         xd[1] = 64'h0; xo[1] = 2'd1; xe[1] = 64'h0;
         xd[2] = 64'h4000000000000000; xo[2] = 2'd3; xe[2] = 64'h7FF8000000000000;
         for (int i = 3; i < 9; i++) begin
            rv    = (real'($urandom_range(0, 2000000)) - 1000000.0) / 1000.0;
            xd[i] = $realtobits(rv);
            xo[i] = 2'(i % 3);
            xe[i] = (xo[i] == 2'd0) ? $realtobits($cos(rv)) :
                    (xo[i] == 2'd1) ? $realtobits($sin(rv)) : $realtobits($tan(rv));
         end
         for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            b_valid = (i < 9); b_data = (i < 9) ? xd[i] : 64'h0; b_op = (i < 9) ? xo[i] : 2'd0;
            b_tag = 4'(i);
            #1;
            if (i > 0) begin
               check("f64_valid", 64'(r64_valid), 64'd1);
               check("f64_data", r64_data, xe[i-1]);
               check("f64_tag", 64'(r64_tag), 64'(i - 1));
            end
            if (i < 9) check("f64_a_ready", 64'(b_ready), 64'd1);
         end
         @(negedge clk);
         #1;
         check("f64_idle_valid", 64'(r64_valid), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
